pwr8_out_serializer: RTL and testbench

//  Downstream stage of the power-of-8 pipeline. Captures each 128-bit result on i_valid,

---
 rtl/pwr8_pkg.sv | 13 +
 rtl/pwr8_out_serializer_if.sv | 25 ++
 rtl/pwr8_result_fifo.sv | 55 +++++
 rtl/pwr8_out_serializer.sv | 111 +++++++++++
 tb/tb_pwr8_out_serializer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pwr8_pkg.sv
// Shared definitions for the power-of-8 pipeline output stage.
package pwr8_pkg;

  localparam int PWR8_DATA_W = 128;
  localparam int PWR8_WORD_W = 32;
  localparam int PWR8_BEATS  = PWR8_DATA_W / PWR8_WORD_W;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } pwr8_state_e;

endpackage

// File: rtl/pwr8_out_serializer_if.sv
// Result input and word-stream output of the serializer.
// master: the serializer; slave: the environment feeding results and consuming words.
interface pwr8_out_serializer_if #(
  parameter int DATA_W = pwr8_pkg::PWR8_DATA_W,
  parameter int WORD_W = pwr8_pkg::PWR8_WORD_W
);

  logic [DATA_W-1:0] i_in;
  logic              i_valid;
  logic              i_ready;
  logic [WORD_W-1:0] o_data;
  logic              o_valid;
  logic              o_last;

  modport master (
    input  i_in, i_valid, i_ready,
    output o_data, o_valid, o_last
  );

  modport slave (
    output i_in, i_valid, i_ready,
    input  o_data, o_valid, o_last
  );

endinterface

// File: rtl/pwr8_result_fifo.sv
// Synchronous result FIFO with show-ahead head, full/empty flags and occupancy.
// The caller must not push when full unless it pops on the same edge.
module pwr8_result_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage write.
  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-2 depth.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_full  = (o_count == CNT_W'(DEPTH));
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/pwr8_out_serializer.sv
// Output stage of the power-of-8 pipeline: buffers 128-bit results and streams
// them LS word first over a valid/ready word interface.
// Optional feature macro: PWR8_DROP_CNT_EN enables the saturating drop counter.
module pwr8_out_serializer
  import pwr8_pkg::*;
#(
  parameter int DATA_W = PWR8_DATA_W,
  parameter int WORD_W = PWR8_WORD_W,
  parameter int DEPTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  pwr8_out_serializer_if.master      bus,
  output logic                       o_overflow,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [15:0]                o_drop_cnt
);

  localparam int BEATS  = DATA_W / WORD_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  pwr8_state_e       state;
  logic [BEAT_W-1:0] beat;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shift;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              handshake;
  logic              last_hs;
  logic              drop;

  assign handshake   = bus.o_valid & bus.i_ready;
  assign last_hs     = handshake & (beat == LAST_BEAT);
  // Pop when idle, or back-to-back on the final beat so results run without a bubble.
  assign fifo_pop    = ~fifo_empty & ((state == S_IDLE) | last_hs);
  // A full FIFO still accepts a result when an entry leaves on the same edge.
  assign fifo_push   = bus.i_valid & (~fifo_full | fifo_pop);
  assign drop        = bus.i_valid & ~fifo_push;
  // The shift register moves down one word per beat, so its low word is always
  // the word selected by the beat counter.
  assign shreg_shift = shreg >> WORD_W;

  pwr8_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (fifo_push),
    .i_wdata   (bus.i_in),
    .i_pop     (fifo_pop),
    .o_head    (fifo_head),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (o_count)
  );

  // Serializer FSM with registered word outputs; o_valid only falls after a
  // last-beat handshake with nothing left to send.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      beat        <= '0;
      shreg       <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_last  <= 1'b0;
    end else if (fifo_pop) begin
      state       <= S_SEND;
      beat        <= '0;
      shreg       <= fifo_head;
      bus.o_valid <= 1'b1;
      bus.o_data  <= fifo_head[WORD_W-1:0];
      bus.o_last  <= (LAST_BEAT == '0);
    end else if (handshake) begin
      if (beat == LAST_BEAT) begin
        state       <= S_IDLE;
        beat        <= '0;
        bus.o_valid <= 1'b0;
        bus.o_data  <= '0;
        bus.o_last  <= 1'b0;
      end else begin
        beat        <= beat + 1'b1;
        shreg       <= shreg_shift;
        bus.o_data  <= shreg_shift[WORD_W-1:0];
        bus.o_last  <= ((beat + 1'b1) == LAST_BEAT);
      end
    end
  end

  // One-cycle pulse for every result that could not be buffered.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_overflow <= 1'b0;
    else            o_overflow <= drop;
  end

`ifdef PWR8_DROP_CNT_EN
  // Saturating count of dropped results, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                         o_drop_cnt <= '0;
    else if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 1'b1;
  end
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pwr8_out_serializer.sv
// Self-checking bench for pwr8_out_serializer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_pwr8_out_serializer;
  import pwr8_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = PWR8_WORD_W;
  localparam int BEATS = PWR8_BEATS;
  localparam int CW    = $clog2(DEPTH+1);

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          o_overflow;
  logic [CW-1:0] o_count;
  logic [15:0]   o_drop_cnt;

  pwr8_out_serializer_if #(.DATA_W(PWR8_DATA_W), .WORD_W(W)) bus ();

  pwr8_out_serializer #(
    .DATA_W (PWR8_DATA_W),
    .WORD_W (W),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .bus        (bus),
    .o_overflow (o_overflow),
    .o_count    (o_count),
    .o_drop_cnt (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: buffered results, the result being sent and its word index.
  logic [127:0] m_q[$];
  logic [127:0] m_cur;
  int           m_idx;
  bit           m_busy;
  bit           m_ovf;
  int           m_drops;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cur   = '0;
    m_idx   = 0;
    m_busy  = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  // One clock edge of the behavioural rules, using pre-edge model state.
  task automatic model_step(input bit v, input logic [127:0] d, input bit r);
    bit hs, pop, acc;
    hs  = m_busy && r;
    pop = (m_q.size() > 0) && (!m_busy || (hs && m_idx == BEATS-1));
    acc = v && ((m_q.size() < DEPTH) || pop);
    if (hs) begin
      m_idx++;
      if (m_idx == BEATS) m_busy = 0;
    end
    if (pop) begin
      m_cur  = m_q.pop_front();
      m_idx  = 0;
      m_busy = 1;
    end
    if (acc) m_q.push_back(d);
    m_ovf = v && !acc;
    if (m_ovf && m_drops < 65535) m_drops++;
  endtask

  task automatic compare_all();
    check("o_valid", bus.o_valid, m_busy);
    if (m_busy) begin
      check("o_data", bus.o_data, m_cur[m_idx*W +: W]);
      check("o_last", bus.o_last, (m_idx == BEATS-1));
    end
    check("o_count", o_count, m_q.size());
    check("o_overflow", o_overflow, m_ovf);
`ifdef PWR8_DROP_CNT_EN
    check("o_drop_cnt", o_drop_cnt, m_drops);
`else
    check("o_drop_cnt", o_drop_cnt, 0);
`endif
  endtask

  // Drive at the falling edge, step the model at the rising edge, compare at the next falling edge.
  task automatic cycle(input bit v, input logic [127:0] d, input bit r);
    bus.i_valid = v;
    bus.i_in    = d;
    bus.i_ready = r;
    @(posedge i_clk);
    model_step(v, d, r);
    @(negedge i_clk);
    compare_all();
  endtask

  function automatic logic [127:0] rand_result();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
  endtask

  int peak;
  int pulses;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_in    = '0;
    bus.i_ready = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(negedge i_clk);
    check("rst_o_data", bus.o_data, 0);
    check("rst_o_last", bus.o_last, 0);
    compare_all();
    i_reset_n = 1'b1;

    // 1: single result, two-cycle latency, LS word first.
    cycle(1'b1, 128'h00000004_00000003_00000002_00000001, 1'b1);
    check("t1_latency_n1", bus.o_valid, 0);
    cycle(1'b0, '0, 1'b1);
    check("t1_latency_n2", bus.o_valid, 1);
    check("t1_word1", bus.o_data, 32'h1);
    drain(6);

    // 2: two results back to back, no bubble, occupancy peaks at 1.
    peak = 0;
    cycle(1'b1, rand_result(), 1'b1);
    if (int'(o_count) > peak) peak = int'(o_count);
    cycle(1'b1, rand_result(), 1'b1);
    if (int'(o_count) > peak) peak = int'(o_count);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (int'(o_count) > peak) peak = int'(o_count);
    end
    check("t2_count_peak", peak, 1);

    // 3: consumer stall mid-result.
    cycle(1'b1, rand_result(), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0);
    drain(6);

    // 4: six results into a stalled consumer -> exactly one drop.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, rand_result(), 1'b0);
      pulses += int'(o_overflow);
    end
    cycle(1'b0, '0, 1'b0);
    pulses += int'(o_overflow);
    check("t4_overflow_pulses", pulses, 1);
    check("t4_count_full", o_count, 4);

    // 5: last-beat handshake while full coincides with a new result.
    for (int i = 0; i < BEATS-1; i++) cycle(1'b0, '0, 1'b1);
    check("t5_on_last", bus.o_last, 1);
    cycle(1'b1, rand_result(), 1'b1);
    check("t5_count_stays", o_count, 4);
    check("t5_no_overflow", o_overflow, 0);
    drain(30);

    // 6: asynchronous reset during word 2, then a clean result.
    cycle(1'b1, rand_result(), 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("t6_word2_valid", bus.o_valid, 1);
    #2 i_reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_valid", bus.o_valid, 0);
    check("t6_async_data", bus.o_data, 0);
    check("t6_async_last", bus.o_last, 0);
    compare_all();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cycle(1'b1, 128'h0000000d_0000000c_0000000b_0000000a, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("t6_restart_word1", bus.o_data, 32'ha);
    drain(6);

    // Random traffic with varying input and consumer rates.
    for (int seg = 0; seg < 12; seg++) begin
      int pv, pr;
      pv = $urandom_range(5, 60);
      pr = $urandom_range(10, 100);
      for (int i = 0; i < 250; i++)
        cycle(($urandom_range(0, 99) < pv), rand_result(), ($urandom_range(0, 99) < pr));
    end
    drain(30);

`ifdef PWR8_DROP_CNT_EN
    // Drop counter saturation: keep the consumer stalled and the input busy.
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 66000; i++) begin
      bus.i_in = rand_result();
      @(posedge i_clk);
      model_step(1'b1, bus.i_in, 1'b0);
      @(negedge i_clk);
      if ((i % 4096) == 0) compare_all();
    end
    compare_all();
    check("drop_cnt_saturated", o_drop_cnt, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
